// File: rtl/bcd_cnt_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_cnt_seq_ctrl : run controller for a BCD up/down counter cascade.     |
// | Optional feature macro: BCD_SEQ_AUTORELOAD_EN (periodic auto-reload).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bcd_cnt_seq_ctrl #(
  parameter int DIGITS = 2,
  parameter int DIV_W  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  CLEAR,
  input  logic                  DIR,
  input  logic [4*DIGITS-1:0]   PRESET,
  input  logic [DIV_W-1:0]      TICK_DIV,
  input  logic                  TC_IN,
  output logic [4*DIGITS-1:0]   LD_DATA,
  output logic                  LOAD,
  output logic                  EN,
  output logic                  UP,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  BAD_PRESET,
  output logic [2:0]            STATE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [DIV_W-1:0] c_div_one = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_presc, w_presc_nxt, w_div_m1;
  logic             r_up, w_up_nxt;
  logic             r_clr_ld;
  logic             r_bad, w_bad_nxt;
  logic             w_preset_bad;
  logic             w_tick;

  always_comb begin
    w_preset_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (PRESET[4*i +: 4] > 4'd9) w_preset_bad = 1'b1;
    end
  end

  // A divide value of zero behaves as divide-by-one.
  assign w_div_m1 = (TICK_DIV == '0) ? '0 : (TICK_DIV - c_div_one);
  assign w_tick   = (r_presc >= w_div_m1);

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_up_nxt    = r_up;
    w_bad_nxt   = 1'b0;
    LOAD        = r_clr_ld;
    LD_DATA     = '0;
    EN          = 1'b0;
    DONE        = 1'b0;

    if (r_state == S_LOAD) begin
      LOAD    = 1'b1;
      LD_DATA = PRESET;
    end

    if (CLEAR) begin
      w_state_nxt = S_IDLE;
      w_presc_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          w_presc_nxt = '0;
          if (START && !STOP) begin
            if (w_preset_bad) begin
              w_bad_nxt = 1'b1;
            end else begin
              w_up_nxt    = DIR;
              w_state_nxt = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          w_presc_nxt = '0;
          w_state_nxt = STOP ? S_PAUSE : S_RUN;
        end
        S_RUN: begin
          if (STOP) begin
            w_state_nxt = S_PAUSE;
          end else begin
            w_presc_nxt = w_tick ? '0 : (r_presc + c_div_one);
            if (w_tick) begin
              if (!TC_IN) begin
                EN = 1'b1;
              end else begin
                DONE = 1'b1;
`ifdef BCD_SEQ_AUTORELOAD_EN
                LOAD    = 1'b1;
                LD_DATA = PRESET;
`else
                w_state_nxt = S_DONE;
`endif
              end
            end
          end
        end
        S_PAUSE: begin
          if (START && !STOP) w_state_nxt = S_RUN;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_up     <= 1'b0;
      r_clr_ld <= 1'b0;
      r_bad    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_presc  <= w_presc_nxt;
      r_up     <= w_up_nxt;
      r_clr_ld <= CLEAR;
      r_bad    <= w_bad_nxt;
    end
  end

  assign UP         = r_up;
  assign BAD_PRESET = r_bad;
  assign BUSY       = (r_state == S_LOAD) || (r_state == S_RUN);
  assign STATE      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bcd_cnt_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bcd_cnt_seq_ctrl : directed self-checking bench with a 2-digit        |
// | BCD cascade model supplying TC_IN. Revision: 1.0                         |
// +--------------------------------------------------------------------------+
module tb_bcd_cnt_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic        CLEAR = 1'b0;
  logic        DIR = 1'b0;
  logic [7:0]  PRESET = 8'h00;
  logic [15:0] TICK_DIV = 16'd0;
  logic        TC_IN;
  logic [7:0]  LD_DATA;
  logic        LOAD, EN, UP, BUSY, DONE, BAD_PRESET;
  logic [2:0]  STATE;
  logic [7:0]  casc = 8'h00;
  int          total = 0;
  int          bad = 0;

  always #5 CLK = ~CLK;

  bcd_cnt_seq_ctrl #(.DIGITS(2), .DIV_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP), .CLEAR(CLEAR),
    .DIR(DIR), .PRESET(PRESET), .TICK_DIV(TICK_DIV), .TC_IN(TC_IN),
    .LD_DATA(LD_DATA), .LOAD(LOAD), .EN(EN), .UP(UP), .BUSY(BUSY),
    .DONE(DONE), .BAD_PRESET(BAD_PRESET), .STATE(STATE)
  );

  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up);
    logic [3:0] lo, hi;
    lo = v[3:0];
    hi = v[7:4];
    if (up) begin
      if (lo == 4'd9) begin lo = 4'd0; hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1; end
      else lo = lo + 4'd1;
    end else begin
      if (lo == 4'd0) begin lo = 4'd9; hi = (hi == 4'd0) ? 4'd9 : hi - 4'd1; end
      else lo = lo - 4'd1;
    end
    return {hi, lo};
  endfunction

  // Digit cascade model driven by the controller outputs.
  always @(posedge CLK) begin
    if (LOAD) casc <= LD_DATA;
    else if (EN) casc <= bcd_step(casc, UP);
  end
  assign TC_IN = UP ? (casc == 8'h99) : (casc == 8'h00);

  task automatic test_reset();
    @(negedge CLK); RESET = 1'b1; START = 1'b1; DIR = 1'b1; PRESET = 8'h12;
    @(negedge CLK); #1;
    total++;
    if ({STATE, LOAD, EN, UP, BUSY, DONE, BAD_PRESET, LD_DATA} !== 17'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", {STATE, LOAD, EN, UP, BUSY, DONE, BAD_PRESET, LD_DATA});
    end
    @(negedge CLK); RESET = 1'b0; START = 1'b0; DIR = 1'b0; PRESET = 8'h00;
  endtask

  task automatic test_countdown();
    @(negedge CLK); PRESET = 8'h03; DIR = 1'b0; TICK_DIV = 16'd4; START = 1'b1; #1;
    total++;
    if (STATE !== 3'd0) begin bad++; $display("FAIL cd_idle: got %0d want 0", STATE); end
    @(negedge CLK); START = 1'b0; #1;
    total++;
    if ({STATE, LOAD, LD_DATA, UP, BUSY, EN} !== {3'd1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL cd_load: got %h want %h", {STATE, LOAD, LD_DATA, UP, BUSY, EN}, {3'd1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0});
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK); #1;
      total++;
      if ({STATE, LOAD, EN, DONE} !== {3'd2, 1'b0, (k % 4 == 3) && (k != 15), k == 15}) begin
        bad++; $display("FAIL cd_run[%0d]: got %b want %b", k, {STATE, LOAD, EN, DONE}, {3'd2, 1'b0, (k % 4 == 3) && (k != 15), k == 15});
      end
    end
    @(negedge CLK); #1;
    total++;
    if ({STATE, BUSY, EN, DONE, casc} !== {3'd4, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      bad++; $display("FAIL cd_done: got %h want %h", {STATE, BUSY, EN, DONE, casc}, {3'd4, 1'b0, 1'b0, 1'b0, 8'h00});
    end
  endtask

  task automatic test_countup_no_wrap();
    @(negedge CLK); PRESET = 8'h97; DIR = 1'b1; TICK_DIV = 16'd0; START = 1'b1;
    @(negedge CLK); START = 1'b0; #1;
    total++;
    if ({STATE, LOAD, LD_DATA, UP} !== {3'd1, 1'b1, 8'h97, 1'b1}) begin
      bad++; $display("FAIL cu_load: got %h want %h", {STATE, LOAD, LD_DATA, UP}, {3'd1, 1'b1, 8'h97, 1'b1});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); #1;
      total++;
      if ({STATE, EN, DONE} !== {3'd2, k < 2, k == 2}) begin
        bad++; $display("FAIL cu_run[%0d]: got %b want %b", k, {STATE, EN, DONE}, {3'd2, k < 2, k == 2});
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); #1;
      total++;
      if ({STATE, EN, casc} !== {3'd4, 1'b0, 8'h99}) begin
        bad++; $display("FAIL cu_hold[%0d]: got %h want %h", k, {STATE, EN, casc}, {3'd4, 1'b0, 8'h99});
      end
    end
  endtask

  task automatic test_pause_resume();
    @(negedge CLK); PRESET = 8'h05; DIR = 1'b0; TICK_DIV = 16'd4; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK); #1;
      total++;
      if ({STATE, EN} !== {3'd2, 1'b0}) begin bad++; $display("FAIL pr_run[%0d]: got %b want 0100", k, {STATE, EN}); end
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK); STOP = 1'b1; #1;
      total++;
      if ({STATE, EN, LOAD} !== {(k == 0) ? 3'd2 : 3'd3, 1'b0, 1'b0}) begin
        bad++; $display("FAIL pr_stop[%0d]: got %b want %b", k, {STATE, EN, LOAD}, {(k == 0) ? 3'd2 : 3'd3, 1'b0, 1'b0});
      end
    end
    @(negedge CLK); STOP = 1'b0; START = 1'b1; #1;
    total++;
    if ({STATE, EN, BUSY} !== {3'd3, 1'b0, 1'b0}) begin bad++; $display("FAIL pr_paused: got %b want 01100", {STATE, EN, BUSY}); end
    @(negedge CLK); START = 1'b0; #1;
    total++;
    if ({STATE, EN, LOAD} !== {3'd2, 1'b0, 1'b0}) begin bad++; $display("FAIL pr_resume: got %b want 01000", {STATE, EN, LOAD}); end
    @(negedge CLK); #1;
    total++;
    if ({STATE, EN, LOAD, casc} !== {3'd2, 1'b1, 1'b0, 8'h05}) begin
      bad++; $display("FAIL pr_tick: got %h want %h", {STATE, EN, LOAD, casc}, {3'd2, 1'b1, 1'b0, 8'h05});
    end
  endtask

  task automatic test_clear();
    @(negedge CLK); CLEAR = 1'b1; START = 1'b1; DIR = 1'b1; #1;
    total++;
    if (STATE !== 3'd2) begin bad++; $display("FAIL clr_pre: got %0d want 2", STATE); end
    @(negedge CLK); CLEAR = 1'b0; START = 1'b0; DIR = 1'b0; #1;
    total++;
    if ({STATE, LOAD, LD_DATA, UP, EN, BUSY} !== {3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL clr_load: got %h want %h", {STATE, LOAD, LD_DATA, UP, EN, BUSY}, {3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
    end
    @(negedge CLK); #1;
    total++;
    if ({STATE, LOAD, casc} !== {3'd0, 1'b0, 8'h00}) begin
      bad++; $display("FAIL clr_after: got %h want %h", {STATE, LOAD, casc}, {3'd0, 1'b0, 8'h00});
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge CLK); PRESET = 8'h50; DIR = 1'b1; TICK_DIV = 16'd3; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    @(negedge CLK); #1;
    total++;
    if (STATE !== 3'd2) begin bad++; $display("FAIL rmr_run: got %0d want 2", STATE); end
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0; #1;
    total++;
    if ({STATE, LOAD, EN, UP, BUSY, DONE, BAD_PRESET, LD_DATA} !== 17'd0) begin
      bad++; $display("FAIL rmr_outputs: got %h want 0", {STATE, LOAD, EN, UP, BUSY, DONE, BAD_PRESET, LD_DATA});
    end
    total++;
    if (casc !== 8'h50) begin bad++; $display("FAIL rmr_cascade_kept: got %h want 50", casc); end
  endtask

  task automatic test_bad_preset();
    @(negedge CLK); PRESET = 8'h1A; START = 1'b1; #1;
    total++;
    if ({STATE, BAD_PRESET} !== {3'd0, 1'b0}) begin bad++; $display("FAIL bp_pre: got %b want 0000", {STATE, BAD_PRESET}); end
    @(negedge CLK); START = 1'b0; #1;
    total++;
    if ({STATE, BAD_PRESET, LOAD} !== {3'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL bp_pulse: got %b want 00010", {STATE, BAD_PRESET, LOAD}); end
    @(negedge CLK); #1;
    total++;
    if ({STATE, BAD_PRESET, LOAD} !== {3'd0, 1'b0, 1'b0}) begin bad++; $display("FAIL bp_after: got %b want 00000", {STATE, BAD_PRESET, LOAD}); end
  endtask

  task automatic test_back_to_back();
    @(negedge CLK); PRESET = 8'h01; DIR = 1'b0; TICK_DIV = 16'd1; START = 1'b1;
    @(negedge CLK); #1;
    total++;
    if ({STATE, LOAD, LD_DATA} !== {3'd1, 1'b1, 8'h01}) begin bad++; $display("FAIL b2b_load1: got %h want 301", {STATE, LOAD, LD_DATA}); end
    @(negedge CLK); #1;
    total++;
    if ({STATE, EN, DONE} !== {3'd2, 1'b1, 1'b0}) begin bad++; $display("FAIL b2b_en: got %b want 01010", {STATE, EN, DONE}); end
    @(negedge CLK); #1;
    total++;
    if ({STATE, EN, DONE} !== {3'd2, 1'b0, 1'b1}) begin bad++; $display("FAIL b2b_done: got %b want 01001", {STATE, EN, DONE}); end
    @(negedge CLK); #1;
    total++;
    if (STATE !== 3'd4) begin bad++; $display("FAIL b2b_done_state: got %0d want 4", STATE); end
    @(negedge CLK); START = 1'b0; #1;
    total++;
    if ({STATE, LOAD, LD_DATA} !== {3'd1, 1'b1, 8'h01}) begin bad++; $display("FAIL b2b_retrigger: got %h want 301", {STATE, LOAD, LD_DATA}); end
  endtask

  task automatic test_autoreload();
    @(negedge CLK); PRESET = 8'h02; DIR = 1'b0; TICK_DIV = 16'd1; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK); #1;
      total++;
      if ({STATE, EN, LOAD, DONE} !== {3'd2, k % 3 != 2, k % 3 == 2, k % 3 == 2}) begin
        bad++; $display("FAIL ar_cycle[%0d]: got %b want %b", k, {STATE, EN, LOAD, DONE}, {3'd2, k % 3 != 2, k % 3 == 2, k % 3 == 2});
      end
      if (k % 3 == 2) begin
        total++;
        if (LD_DATA !== 8'h02) begin bad++; $display("FAIL ar_ld_data[%0d]: got %h want 02", k, LD_DATA); end
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef BCD_SEQ_AUTORELOAD_EN
    test_bad_preset();
    test_autoreload();
`else
    test_countdown();
    test_countup_no_wrap();
    test_pause_resume();
    test_clear();
    test_reset_mid_run();
    test_bad_preset();
    test_back_to_back();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
